// File: rtl/ram_pkg.sv
// Shared constants and typedefs for the 4096 x 64 dual-port RAM and its
// verification environment.
package ram_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int ADDR_WIDTH = 12;
    localparam int DEPTH      = 4096;

    typedef logic [DATA_WIDTH-1:0] ram_data_t;
    typedef logic [ADDR_WIDTH-1:0] ram_addr_t;

endpackage : ram_pkg

// File: rtl/ram_4096_array.sv
// Plain 4096 x 64 storage: synchronous write, combinational-address read.
// Deliberately reset-free so it maps onto block RAM.
module ram_4096_array
    import ram_pkg::*;
(
    input  logic      clk,
    input  logic      we,
    input  ram_addr_t wr_addr,
    input  ram_data_t wr_data,
    input  ram_addr_t rd_addr,
    output ram_data_t rd_data
);

    ram_data_t mem_r [DEPTH];

    // Storage write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule : ram_4096_array

// File: rtl/dp_ram_4096.sv
// Simple dual-port 4096 x 64 RAM with per-word valid bits and registered read.
// Define RAM_BYPASS_EN to forward write data on a same-address collision.
module dp_ram_4096
    import ram_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH-1:0] wr_address,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] rd_address,
    input  logic                  read,
    output logic [DATA_WIDTH-1:0] data_out
);

    logic [DEPTH-1:0] valid_r;
    ram_data_t        arr_rd_data_s;
    ram_data_t        rd_next_s;
    logic             collision_s;
    logic             arr_we_s;

    // Writes are dropped while reset is held so the array stays untouched.
    assign arr_we_s    = write & rst_n;
    assign collision_s = write & read & (wr_address == rd_address);

    ram_4096_array u_array (
        .clk     (clk),
        .we      (arr_we_s),
        .wr_addr (wr_address),
        .wr_data (data_in),
        .rd_addr (rd_address),
        .rd_data (arr_rd_data_s)
    );

    // Valid-bit tracking: set on write, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= {DEPTH{1'b0}};
        end else if (write) begin
            valid_r[wr_address] <= 1'b1;
        end
    end

    // Read data selection including collision handling
    always_comb begin
        rd_next_s = {DATA_WIDTH{1'b0}};
`ifdef RAM_BYPASS_EN
        if (collision_s) begin
            rd_next_s = data_in;
        end else if (valid_r[rd_address]) begin
            rd_next_s = arr_rd_data_s;
        end else begin
            rd_next_s = {DATA_WIDTH{1'b0}};
        end
`else
        // Array and valid bits still hold pre-write state: read-before-write.
        if (valid_r[rd_address]) begin
            rd_next_s = arr_rd_data_s;
        end else begin
            rd_next_s = {DATA_WIDTH{1'b0}};
        end
`endif
    end

    // Registered read output, held when read is idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= {DATA_WIDTH{1'b0}};
        end else if (read) begin
            data_out <= rd_next_s;
        end
    end

endmodule : dp_ram_4096

// File: tb/tb_dp_ram_4096.sv
// Self-checking bench for dp_ram_4096: directed scenarios plus a random soak
// against an array-based reference model. Honours RAM_BYPASS_EN.
module tb_dp_ram_4096;
    import ram_pkg::*;

    logic      clk;
    logic      rst_n;
    ram_data_t data_in;
    ram_addr_t wr_address;
    logic      write;
    ram_addr_t rd_address;
    logic      read;
    ram_data_t data_out;

    int checks = 0;
    int errors = 0;

    ram_data_t mdl_mem   [DEPTH];
    bit        mdl_valid [DEPTH];
    ram_data_t exp_out;

    dp_ram_4096 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .wr_address (wr_address),
        .write      (write),
        .rd_address (rd_address),
        .read       (read),
        .data_out   (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ram_data_t mdl_read(input ram_addr_t a);
        return mdl_valid[a] ? mdl_mem[a] : 64'h0;
    endfunction

    task automatic mdl_clear();
        for (int i = 0; i < DEPTH; i++) mdl_valid[i] = 1'b0;
        exp_out = 64'h0;
    endtask

    // One clock of traffic; model updated from the behavioural rules, then
    // returns 1 ns after the edge with inputs idled.
    task automatic do_cycle(input bit w, input ram_addr_t wa, input ram_data_t d,
                            input bit r, input ram_addr_t ra);
        @(negedge clk);
        write = w; wr_address = wa; data_in = d;
        read = r;  rd_address = ra;
        @(posedge clk);
        if (r) begin
`ifdef RAM_BYPASS_EN
            if (w && wa == ra) exp_out = d;
            else exp_out = mdl_read(ra);
`else
            exp_out = mdl_read(ra);
`endif
        end
        if (w) begin
            mdl_mem[wa]   = d;
            mdl_valid[wa] = 1'b1;
        end
        #1;
        write = 1'b0; read = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; write = 1'b0; read = 1'b0;
        data_in = 64'h0; wr_address = 12'h0; rd_address = 12'h0;
        mdl_clear();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (data_out !== 64'h0) begin
            errors++;
            $display("FAIL reset_out: got %h want %h", data_out, 64'h0);
        end
        // A write attempted under reset must not make the word valid.
        @(negedge clk);
        write = 1'b1; wr_address = 12'h000; data_in = 64'h1234;
        @(negedge clk);
        write = 1'b0;
        rst_n = 1'b1;
        do_cycle(1'b0, 12'h0, 64'h0, 1'b1, 12'h000);
        checks++;
        if (data_out !== 64'h0) begin
            errors++;
            $display("FAIL reset_read_000: got %h want %h", data_out, 64'h0);
        end
        do_cycle(1'b0, 12'h0, 64'h0, 1'b1, 12'hFFF);
        checks++;
        if (data_out !== 64'h0) begin
            errors++;
            $display("FAIL reset_read_fff: got %h want %h", data_out, 64'h0);
        end
    endtask

    task automatic test_write_read();
        do_cycle(1'b1, 12'h5A5, 64'hDEAD_BEEF_0123_4567, 1'b0, 12'h0);
        do_cycle(1'b0, 12'h0, 64'h0, 1'b1, 12'h5A5);
        checks++;
        if (data_out !== 64'hDEAD_BEEF_0123_4567) begin
            errors++;
            $display("FAIL write_read: got %h want %h", data_out, 64'hDEAD_BEEF_0123_4567);
        end
        // read idle: output holds
        do_cycle(1'b1, 12'h5A5, 64'h0, 1'b0, 12'h000);
        checks++;
        if (data_out !== 64'hDEAD_BEEF_0123_4567) begin
            errors++;
            $display("FAIL read_idle_hold: got %h want %h", data_out, 64'hDEAD_BEEF_0123_4567);
        end
    endtask

    task automatic test_boundary();
        do_cycle(1'b1, 12'hFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 12'h0);
        do_cycle(1'b1, 12'h000, 64'h1, 1'b0, 12'h0);
        do_cycle(1'b0, 12'h0, 64'h0, 1'b1, 12'hFFF);
        checks++;
        if (data_out !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++;
            $display("FAIL boundary_fff: got %h want %h", data_out, 64'hFFFF_FFFF_FFFF_FFFF);
        end
        do_cycle(1'b0, 12'h0, 64'h0, 1'b1, 12'h000);
        checks++;
        if (data_out !== 64'h1) begin
            errors++;
            $display("FAIL boundary_000: got %h want %h", data_out, 64'h1);
        end
        // Simultaneous write and read at different addresses
        do_cycle(1'b1, 12'h7FF, 64'h0BAD_F00D, 1'b1, 12'hFFF);
        checks++;
        if (data_out !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++;
            $display("FAIL dual_port: got %h want %h", data_out, 64'hFFFF_FFFF_FFFF_FFFF);
        end
    endtask

    task automatic test_collision();
        ram_data_t want;
        do_cycle(1'b1, 12'h100, 64'hAA, 1'b0, 12'h0);
        do_cycle(1'b1, 12'h100, 64'hBB, 1'b1, 12'h100);
`ifdef RAM_BYPASS_EN
        want = 64'hBB;
`else
        want = 64'hAA;
`endif
        checks++;
        if (data_out !== want) begin
            errors++;
            $display("FAIL collision: got %h want %h", data_out, want);
        end
        do_cycle(1'b0, 12'h0, 64'h0, 1'b1, 12'h100);
        checks++;
        if (data_out !== 64'hBB) begin
            errors++;
            $display("FAIL collision_after: got %h want %h", data_out, 64'hBB);
        end
        // Collision on a never-written word
`ifdef RAM_BYPASS_EN
        want = 64'hCC;
`else
        want = 64'h0;
`endif
        do_cycle(1'b1, 12'h200, 64'hCC, 1'b1, 12'h200);
        checks++;
        if (data_out !== want) begin
            errors++;
            $display("FAIL collision_invalid: got %h want %h", data_out, want);
        end
    endtask

    task automatic test_mid_reset();
        do_cycle(1'b1, 12'h333, 64'h55, 1'b0, 12'h0);
        do_cycle(1'b0, 12'h0, 64'h0, 1'b1, 12'h333);
        checks++;
        if (data_out !== 64'h55) begin
            errors++;
            $display("FAIL mid_reset_pre: got %h want %h", data_out, 64'h55);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (data_out !== 64'h0) begin
            errors++;
            $display("FAIL mid_reset_async: got %h want %h", data_out, 64'h0);
        end
        mdl_clear();
        @(negedge clk);
        rst_n = 1'b1;
        do_cycle(1'b0, 12'h0, 64'h0, 1'b1, 12'h333);
        checks++;
        if (data_out !== 64'h0) begin
            errors++;
            $display("FAIL mid_reset_read: got %h want %h", data_out, 64'h0);
        end
    endtask

    task automatic test_random_soak();
        bit        w, r;
        ram_addr_t wa, ra;
        ram_data_t d;
        for (int n = 0; n < 500; n++) begin
            w  = ($urandom_range(0, 99) < 55);
            r  = ($urandom_range(0, 99) < 60);
            // Narrow address window half the time to provoke collisions and rereads
            wa = ($urandom_range(0, 1) == 0) ? ram_addr_t'($urandom_range(0, 15))
                                             : ram_addr_t'($urandom);
            ra = ($urandom_range(0, 1) == 0) ? ram_addr_t'($urandom_range(0, 15))
                                             : ram_addr_t'($urandom);
            d  = {$urandom, $urandom};
            do_cycle(w, wa, d, r, ra);
            checks++;
            if (data_out !== exp_out) begin
                errors++;
                $display("FAIL soak[%0d] w=%0b wa=%h r=%0b ra=%h: got %h want %h",
                         n, w, wa, r, ra, data_out, exp_out);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_boundary();
        test_collision();
        test_mid_reset();
        test_random_soak();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_dp_ram_4096
